// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } div_state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
// Responder on the go/done/div_by_zero handshake.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero,
  output logic             err
);

  div_state_t       st;
  logic [WIDTH-1:0] pr;
  logic [WIDTH-1:0] qr;
  logic [WIDTH-1:0] dr;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   p_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] p_nx;
  logic [WIDTH-1:0] q_nx;
  logic             last;

  assign div_by_zero = (y == '0);

  // Partial remainder is always below the divisor, so its
  // shifted value fits in WIDTH+1 bits with no overflow.
  always_comb begin
    p_sh  = {pr, qr[WIDTH-1]};
    trial = p_sh - {1'b0, dr};
    p_nx  = p_sh[WIDTH-1:0];
    q_nx  = {qr[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      p_nx    = trial[WIDTH-1:0];
      q_nx[0] = 1'b1;
    end
    last = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st   <= S_IDLE;
      pr   <= '0;
      qr   <= '0;
      dr   <= '0;
      cnt  <= '0;
      q    <= '0;
      r    <= '0;
      done <= 1'b0;
      busy <= 1'b0;
      err  <= 1'b0;
    end else begin
      unique case (st)
        S_IDLE, S_DONE: begin
          if (go) begin
            if (y == '0) begin
              st   <= S_DONE;
              done <= 1'b1;
              err  <= 1'b1;
              busy <= 1'b0;
              q    <= '1;
              r    <= x;
            end else begin
              st   <= S_BUSY;
              qr   <= x;
              dr   <= y;
              pr   <= '0;
              cnt  <= '0;
              done <= 1'b0;
              err  <= 1'b0;
              busy <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          pr  <= p_nx;
          qr  <= q_nx;
          cnt <= cnt + CW'(1);
          if (last) begin
            st   <= S_DONE;
            q    <= q_nx;
            r    <= p_nx;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard-driven bench for seq_divider at WIDTH=4.
module tb_seq_divider;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       go;
  logic [3:0] x;
  logic [3:0] y;
  logic [3:0] q;
  logic [3:0] r;
  logic       done;
  logic       busy;
  logic       div_by_zero;
  logic       err;

  int   pass_cnt = 0;
  int   total    = 0;
  exp_t sb[$];

  seq_divider #(.WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .go(go),
    .x(x),
    .y(y),
    .q(q),
    .r(r),
    .done(done),
    .busy(busy),
    .div_by_zero(div_by_zero),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1);
  end

  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    if (b == 4'd0) begin
      e.q = 4'hF;
      e.r = a;
      e.err = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.err = 1'b0;
    end
    return e;
  endfunction

  // Drives one operation and measures it; comparisons live in the tests.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input bit poll, output int lat, output int bcnt,
                        output logic d1, output logic b1, output bit held);
    logic [3:0] q0;
    logic [3:0] r0;
    q0 = q;
    r0 = r;
    held = 1'b1;
    lat = 0;
    bcnt = 0;
    d1 = 1'b0;
    b1 = 1'b0;
    x = a;
    y = b;
    go = 1'b1;
    sb.push_back(model(a, b));
    do begin
      @(posedge clk);
      #1;
      lat++;
      go = 1'b0;
      if (lat == 1) begin
        d1 = done;
        b1 = busy;
      end
      if (busy) bcnt++;
      if (busy && (q !== q0 || r !== r0)) held = 1'b0;
      if (poll && busy) begin
        go = lat[0];
        x = 4'd9;
        y = 4'd2;
      end
    end while (!done && lat < 20);
    go = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    go = 1'b0;
    x = 4'd0;
    y = 4'd1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({q, r, done, busy, err} !== 11'd0)
      $display("FAIL reset_outputs got=%b exp=0", {q, r, done, busy, err});
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({done, busy} !== 2'b00)
      $display("FAIL reset_idle got=%b exp=00", {done, busy});
    else pass_cnt++;
  endtask

  task automatic test_basic;
    int lat, bcnt, hold;
    logic d1, b1;
    bit held;
    exp_t e;
    run_op(4'd13, 4'd3, 1'b0, lat, bcnt, d1, b1, held);
    e = sb.pop_front();
    total++;
    if ({q, r, err, done} !== {e.q, e.r, e.err, 1'b1})
      $display("FAIL basic_result got q=%0d r=%0d err=%b done=%b exp q=%0d r=%0d err=%b done=1",
               q, r, err, done, e.q, e.r, e.err);
    else pass_cnt++;
    total++;
    if (lat != 5 || bcnt != 4)
      $display("FAIL basic_latency got lat=%0d busy=%0d exp lat=5 busy=4", lat, bcnt);
    else pass_cnt++;
    hold = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 && q === e.q && r === e.r && busy === 1'b0) hold++;
    end
    total++;
    if (hold != 10)
      $display("FAIL basic_sticky got=%0d exp=10", hold);
    else pass_cnt++;
  endtask

  task automatic test_div_by_zero;
    int lat, bcnt;
    logic d1, b1;
    bit held;
    exp_t e;
    y = 4'd3;
    #1;
    total++;
    if (div_by_zero !== 1'b0)
      $display("FAIL dbz_flag_nonzero got=%b exp=0", div_by_zero);
    else pass_cnt++;
    x = 4'd7;
    y = 4'd0;
    #1;
    total++;
    if (div_by_zero !== 1'b1)
      $display("FAIL dbz_flag_pre got=%b exp=1", div_by_zero);
    else pass_cnt++;
    run_op(4'd7, 4'd0, 1'b0, lat, bcnt, d1, b1, held);
    e = sb.pop_front();
    total++;
    if ({q, r, err, done} !== {e.q, e.r, e.err, 1'b1})
      $display("FAIL dbz_result got q=%0d r=%0d err=%b done=%b exp q=%0d r=%0d err=%b done=1",
               q, r, err, done, e.q, e.r, e.err);
    else pass_cnt++;
    total++;
    if (lat != 1 || bcnt != 0)
      $display("FAIL dbz_latency got lat=%0d busy=%0d exp lat=1 busy=0", lat, bcnt);
    else pass_cnt++;
  endtask

  task automatic test_edges;
    logic [3:0] ta [4] = '{4'd15, 4'd3, 4'd15, 4'd0};
    logic [3:0] tb [4] = '{4'd1, 4'd7, 4'd15, 4'd5};
    int lat, bcnt;
    logic d1, b1;
    bit held;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], 1'b0, lat, bcnt, d1, b1, held);
      e = sb.pop_front();
      total++;
      if ({q, r, err} !== {e.q, e.r, e.err})
        $display("FAIL edge_%0d_%0d got q=%0d r=%0d err=%b exp q=%0d r=%0d err=%b",
                 ta[i], tb[i], q, r, err, e.q, e.r, e.err);
      else pass_cnt++;
      total++;
      if (lat != 5 || bcnt != 4 || done !== 1'b1)
        $display("FAIL edge_lat_%0d_%0d got lat=%0d busy=%0d done=%b exp 5/4/1",
                 ta[i], tb[i], lat, bcnt, done);
      else pass_cnt++;
    end
  endtask

  task automatic test_polling;
    int lat, bcnt;
    logic d1, b1;
    bit held;
    exp_t e;
    run_op(4'd13, 4'd3, 1'b1, lat, bcnt, d1, b1, held);
    e = sb.pop_front();
    total++;
    if ({q, r, err, done} !== {e.q, e.r, e.err, 1'b1})
      $display("FAIL poll_result got q=%0d r=%0d err=%b done=%b exp q=%0d r=%0d err=%b done=1",
               q, r, err, done, e.q, e.r, e.err);
    else pass_cnt++;
    total++;
    if (lat != 5 || bcnt != 4)
      $display("FAIL poll_latency got lat=%0d busy=%0d exp lat=5 busy=4", lat, bcnt);
    else pass_cnt++;
  endtask

  task automatic test_restart;
    int lat, bcnt;
    logic d1, b1;
    bit held;
    exp_t e;
    run_op(4'd13, 4'd3, 1'b0, lat, bcnt, d1, b1, held);
    e = sb.pop_front();
    total++;
    if ({q, r} !== {e.q, e.r})
      $display("FAIL restart_first got q=%0d r=%0d exp q=%0d r=%0d", q, r, e.q, e.r);
    else pass_cnt++;
    run_op(4'd14, 4'd4, 1'b0, lat, bcnt, d1, b1, held);
    e = sb.pop_front();
    total++;
    if ({d1, b1} !== 2'b01)
      $display("FAIL restart_accept got done=%b busy=%b exp done=0 busy=1", d1, b1);
    else pass_cnt++;
    total++;
    if (!held)
      $display("FAIL restart_hold got=changed exp=held");
    else pass_cnt++;
    total++;
    if ({q, r, done, lat} !== {e.q, e.r, 1'b1, 32'd5})
      $display("FAIL restart_result got q=%0d r=%0d done=%b lat=%0d exp q=%0d r=%0d done=1 lat=5",
               q, r, done, lat, e.q, e.r);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int lat, bcnt;
    logic d1, b1;
    bit held;
    exp_t e;
    x = 4'd13;
    y = 4'd3;
    go = 1'b1;
    sb.push_back(model(4'd13, 4'd3));
    @(posedge clk);
    #1;
    go = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1)
      $display("FAIL rstmid_busy got=%b exp=1", busy);
    else pass_cnt++;
    rst = 1'b0;
    void'(sb.pop_back());
    #1;
    total++;
    if ({q, r, done, busy, err} !== 11'd0)
      $display("FAIL rstmid_clear got=%b exp=0", {q, r, done, busy, err});
    else pass_cnt++;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_op(4'd10, 4'd3, 1'b0, lat, bcnt, d1, b1, held);
    e = sb.pop_front();
    total++;
    if ({q, r, done, err} !== {e.q, e.r, 1'b1, e.err})
      $display("FAIL rstmid_rerun got q=%0d r=%0d done=%b exp q=%0d r=%0d done=1",
               q, r, done, e.q, e.r);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_by_zero();
    test_edges();
    test_polling();
    test_restart();
    test_reset_mid();
    total++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_empty got=%0d exp=0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
